keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 235 +++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column strobe, classifies each
// four-column frame, and debounces single-key presses and releases over whole frames.
module keypad_scanner #(
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int                CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [3:0]       DEB_N    = 4'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CNT = 2'd1,
    HELD      = 2'd2,
    REL_CNT   = 2'd3
  } state_t;

  function automatic logic [2:0] count_low(input logic [3:0] r);
    count_low = 3'd0;
    for (int i = 0; i < 4; i++) begin
      count_low = count_low + {2'b00, ~r[i]};
    end
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] r);
    case (r)
      4'b1110: low_index = 2'd0;
      4'b1101: low_index = 2'd1;
      4'b1011: low_index = 2'd2;
      4'b0111: low_index = 2'd3;
      default: low_index = 2'd0;
    endcase
  endfunction

  logic [3:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       col_q, col_d;
  logic [1:0]       low_cnt_q, low_cnt_d;
  logic [3:0]       acc_code_q, acc_code_d;
  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       key_q, key_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;

  logic             tick_s;
  logic             frame_end_s;
  logic             frame_single_s;
  logic [3:0]       frame_code_s;
  logic [2:0]       n_low_s;
  logic [1:0]       base_cnt_s;
  logic [2:0]       sum_s;
  logic [1:0]       sum_sat_s;
  logic [3:0]       code_s;
  logic [3:0]       cnt_inc_s;

  // Scan timing, column strobe and per-frame low-bit accumulation.
  always_comb begin
    sync1_d = row;
    sync2_d = sync1_q;
    tick_s  = (tick_cnt_q == TICK_MAX);
    if (tick_s) begin
      tick_cnt_d = {CNT_W{1'b0}};
      col_idx_d  = col_idx_q + 2'd1;
    end else begin
      tick_cnt_d = tick_cnt_q + CNT_W'(1);
      col_idx_d  = col_idx_q;
    end
    col_d = ~(4'b0001 << col_idx_d);

    // Column 0 starts a fresh frame; the count saturates at 2 (multi-key).
    n_low_s = count_low(sync2_q);
    if (col_idx_q == 2'd0) begin
      base_cnt_s = 2'd0;
    end else begin
      base_cnt_s = low_cnt_q;
    end
    sum_s = {1'b0, base_cnt_s} + n_low_s;
    if (sum_s >= 3'd2) begin
      sum_sat_s = 2'd2;
    end else begin
      sum_sat_s = sum_s[1:0];
    end
    if (n_low_s == 3'd1) begin
      code_s = {low_index(sync2_q), col_idx_q};
    end else begin
      code_s = acc_code_q;
    end
    if (tick_s) begin
      low_cnt_d  = sum_sat_s;
      acc_code_d = code_s;
    end else begin
      low_cnt_d  = low_cnt_q;
      acc_code_d = acc_code_q;
    end

    frame_end_s    = tick_s && (col_idx_q == 2'd3);
    frame_single_s = (sum_sat_s == 2'd1);
    frame_code_s   = code_s;
  end

  // Debounce state machine, evaluated once per completed frame.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    cnt_inc_s   = cnt_q + 4'd1;
    if (frame_end_s) begin
      case (state_q)
        IDLE: begin
          if (frame_single_s) begin
            cand_d = frame_code_s;
            if (DEB_N == 4'd1) begin
              key_d       = frame_code_s;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              cnt_d       = 4'd0;
              state_d     = HELD;
            end else begin
              cnt_d   = 4'd1;
              state_d = PRESS_CNT;
            end
          end else begin
            state_d = IDLE;
          end
        end
        PRESS_CNT: begin
          if (frame_single_s && (frame_code_s == cand_q)) begin
            cnt_d = cnt_inc_s;
            if (cnt_inc_s >= DEB_N) begin
              key_d       = cand_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              state_d     = HELD;
            end else begin
              state_d = PRESS_CNT;
            end
          end else begin
            cnt_d   = 4'd0;
            state_d = IDLE;
          end
        end
        HELD: begin
          key_held_d = 1'b1;
          if (!frame_single_s) begin
            if (DEB_N == 4'd1) begin
              key_held_d = 1'b0;
              cnt_d      = 4'd0;
              state_d    = IDLE;
            end else begin
              cnt_d   = 4'd1;
              state_d = REL_CNT;
            end
          end else begin
            state_d = HELD;
          end
        end
        REL_CNT: begin
          if (frame_single_s) begin
            key_held_d = 1'b1;
            state_d    = HELD;
          end else if (cnt_inc_s >= DEB_N) begin
            key_held_d = 1'b0;
            cnt_d      = 4'd0;
            state_d    = IDLE;
          end else begin
            key_held_d = 1'b1;
            cnt_d      = cnt_inc_s;
            state_d    = REL_CNT;
          end
        end
        default: begin
          key_held_d = 1'b0;
          cnt_d      = 4'd0;
          state_d    = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // All state registers; reset wins over any frame end on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q     <= 4'b1111;
      sync2_q     <= 4'b1111;
      tick_cnt_q  <= {CNT_W{1'b0}};
      col_idx_q   <= 2'd0;
      col_q       <= 4'b1110;
      low_cnt_q   <= 2'd0;
      acc_code_q  <= 4'd0;
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      cand_q      <= 4'd0;
      key_q       <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      tick_cnt_q  <= tick_cnt_d;
      col_idx_q   <= col_idx_d;
      col_q       <= col_d;
      low_cnt_q   <= low_cnt_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col       = col_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_FRAMES=2, 16 clocks/frame)
// with a behavioural key matrix; frame ends fall on every 16th edge after reset.
module tb_keypad_scanner;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_held;
  logic [15:0] mask;
  int          checks = 0;
  int          failures = 0;
  int          kv_count = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clock = ~clock;

  // Key matrix: a pressed key {r,c} pulls row r low while column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (mask[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (key_valid === 1'b1) kv_count <= kv_count + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    mask  = 16'h0000;
    mask[6] = 1'b1;
    tick(2);
    check("rst_col", int'(col), 32'he);
    check("rst_key", int'(key), 0);
    check("rst_valid", int'(key_valid), 0);
    check("rst_held", int'(key_held), 0);
    reset = 1'b0;

    tick(3);
    check("col0_hold", int'(col), 32'he);
    tick(1);
    check("col1", int'(col), 32'hd);
    tick(8);
    check("col3", int'(col), 32'h7);
    tick(19);
    check("press_pre_valid", int'(key_valid), 0);
    check("press_pre_held", int'(key_held), 0);
    tick(1);
    check("press_valid", int'(key_valid), 1);
    check("press_key", int'(key), 6);
    check("press_held", int'(key_held), 1);
    tick(1);
    check("press_pulse_end", int'(key_valid), 0);
    check("press_held2", int'(key_held), 1);
    check("press_count", kv_count, 1);

    mask = 16'h0000;
    tick(30);
    check("rel_held_pre", int'(key_held), 1);
    tick(1);
    check("rel_held", int'(key_held), 0);
    check("rel_key", int'(key), 6);
    check("rel_count", kv_count, 1);

    mask[0]  = 1'b1;
    mask[11] = 1'b1;
    tick(80);
    check("ghost_held_mid", int'(key_held), 0);
    tick(80);
    check("ghost_held", int'(key_held), 0);
    check("ghost_count", kv_count, 1);

    mask = 16'h0000;
    mask[13] = 1'b1;
    tick(16);
    check("bounce_held1", int'(key_held), 0);
    mask = 16'h0000;
    tick(16);
    mask[13] = 1'b1;
    tick(16);
    check("bounce_held2", int'(key_held), 0);
    mask = 16'h0000;
    tick(48);
    check("bounce_count", kv_count, 1);
    check("bounce_key", int'(key), 6);

    mask[6] = 1'b1;
    tick(31);
    check("rep_pre_valid", int'(key_valid), 0);
    tick(1);
    check("rep_valid", int'(key_valid), 1);
    check("rep_held", int'(key_held), 1);
    tick(8);
    reset = 1'b1;
    tick(1);
    check("hrst_col", int'(col), 32'he);
    check("hrst_key", int'(key), 0);
    check("hrst_held", int'(key_held), 0);
    check("hrst_valid", int'(key_valid), 0);
    check("hrst_count", kv_count, 2);
    reset = 1'b0;
    tick(31);
    check("reacc_pre_valid", int'(key_valid), 0);
    check("reacc_pre_held", int'(key_held), 0);
    tick(1);
    check("reacc_valid", int'(key_valid), 1);
    check("reacc_key", int'(key), 6);
    check("reacc_held", int'(key_held), 1);

    tick(1600);
    check("long_held", int'(key_held), 1);
    check("long_count", kv_count, 3);
    mask = 16'h0000;
    mask[13] = 1'b1;
    tick(160);
    check("swap_key", int'(key), 6);
    check("swap_held", int'(key_held), 1);
    check("swap_count", kv_count, 3);
    check("swap_valid", int'(key_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
